// File: rtl/dram_cmd_arbiter.sv
//------------------------------------------------------------------------------
// Module : dram_cmd_arbiter
// Brief  : Per-bank command arbiter enforcing tRRD/tCCD/tWTR/tRTW; one
//          registered DFI-bound command per cycle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dram_cmd_arbiter #(
    parameter int NUM_BANKS = 4,
    parameter int BA_WIDTH  = 2,
    parameter int RA_WIDTH  = 16,
    parameter int CA_WIDTH  = 10,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 4,
    parameter int T_WIDTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [T_WIDTH-1:0]             t_rrd_m1,
    input  logic [T_WIDTH-1:0]             t_ccd_m1,
    input  logic [T_WIDTH-1:0]             t_wtr_m1,
    input  logic [T_WIDTH-1:0]             t_rtw_m1,
    input  logic [NUM_BANKS-1:0]           act_req,
    input  logic [NUM_BANKS-1:0]           rd_req,
    input  logic [NUM_BANKS-1:0]           wr_req,
    input  logic [NUM_BANKS-1:0]           pre_req,
    input  logic [NUM_BANKS-1:0]           ref_req,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]  ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]  ca_i,
    input  logic [NUM_BANKS*ID_WIDTH-1:0]  id_i,
    input  logic [NUM_BANKS*LEN_WIDTH-1:0] len_i,
    output logic [NUM_BANKS-1:0]           act_gnt,
    output logic [NUM_BANKS-1:0]           rd_gnt,
    output logic [NUM_BANKS-1:0]           wr_gnt,
    output logic [NUM_BANKS-1:0]           pre_gnt,
    output logic [NUM_BANKS-1:0]           ref_gnt,
    output logic                           cmd_valid,
    output logic [2:0]                     cmd_type,
    output logic [BA_WIDTH-1:0]            cmd_ba,
    output logic [RA_WIDTH-1:0]            cmd_ra,
    output logic [CA_WIDTH-1:0]            cmd_ca,
    output logic [ID_WIDTH-1:0]            cmd_id,
    output logic [LEN_WIDTH-1:0]           cmd_len
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    logic [T_WIDTH-1:0]  r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
    logic [BA_WIDTH-1:0] r_rr_ptr;

    logic                w_rd_ok, w_wr_ok, w_act_ok;
    logic [NUM_BANKS-1:0] w_col_req, w_act_req;
    logic [BA_WIDTH:0]   w_ref_pick, w_col_pick, w_act_pick, w_pre_pick;
    logic                w_gnt_valid;
    logic [2:0]          w_gnt_type;
    logic [BA_WIDTH-1:0] w_gnt_ba;

    // Returns {found, bank}; the lowest offset from ptr wins, so scan offsets
    // from the far end and let closer hits overwrite.
    function automatic logic [BA_WIDTH:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                                  input logic [BA_WIDTH-1:0]  ptr);
        logic [BA_WIDTH:0]   res;
        logic [BA_WIDTH-1:0] idx;
        res = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            idx = ptr + i[BA_WIDTH-1:0];
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [T_WIDTH-1:0] sat_dec(input logic [T_WIDTH-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    always_comb begin
        w_rd_ok    = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
        w_wr_ok    = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);
        w_act_ok   = (r_rrd_cnt == '0);
        w_col_req  = (rd_req & {NUM_BANKS{w_rd_ok}}) | (wr_req & {NUM_BANKS{w_wr_ok}});
        w_act_req  = act_req & {NUM_BANKS{w_act_ok}};
        w_ref_pick = rr_pick(ref_req, r_rr_ptr);
        w_col_pick = rr_pick(w_col_req, r_rr_ptr);
        w_act_pick = rr_pick(w_act_req, r_rr_ptr);
        w_pre_pick = rr_pick(pre_req, r_rr_ptr);

        w_gnt_valid = 1'b0;
        w_gnt_type  = CMD_NOP;
        w_gnt_ba    = '0;
        if (w_ref_pick[BA_WIDTH]) begin
            w_gnt_valid = 1'b1;
            w_gnt_type  = CMD_REF;
            w_gnt_ba    = w_ref_pick[BA_WIDTH-1:0];
        end else if (w_col_pick[BA_WIDTH]) begin
            w_gnt_valid = 1'b1;
            w_gnt_ba    = w_col_pick[BA_WIDTH-1:0];
            // RD beats WR on the same bank whenever RD is currently legal
            w_gnt_type  = (rd_req[w_gnt_ba] && w_rd_ok) ? CMD_RD : CMD_WR;
        end else if (w_act_pick[BA_WIDTH]) begin
            w_gnt_valid = 1'b1;
            w_gnt_type  = CMD_ACT;
            w_gnt_ba    = w_act_pick[BA_WIDTH-1:0];
        end else if (w_pre_pick[BA_WIDTH]) begin
            w_gnt_valid = 1'b1;
            w_gnt_type  = CMD_PRE;
            w_gnt_ba    = w_pre_pick[BA_WIDTH-1:0];
        end
    end

    always_comb begin
        act_gnt = '0;
        rd_gnt  = '0;
        wr_gnt  = '0;
        pre_gnt = '0;
        ref_gnt = '0;
        case (w_gnt_type)
            CMD_ACT: act_gnt[w_gnt_ba] = 1'b1;
            CMD_RD:  rd_gnt[w_gnt_ba]  = 1'b1;
            CMD_WR:  wr_gnt[w_gnt_ba]  = 1'b1;
            CMD_PRE: pre_gnt[w_gnt_ba] = 1'b1;
            CMD_REF: ref_gnt[w_gnt_ba] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrd_cnt <= '0;
            r_ccd_cnt <= '0;
            r_wtr_cnt <= '0;
            r_rtw_cnt <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_rrd_cnt <= (w_gnt_type == CMD_ACT) ? t_rrd_m1 : sat_dec(r_rrd_cnt);
            r_ccd_cnt <= (w_gnt_type == CMD_RD || w_gnt_type == CMD_WR) ? t_ccd_m1
                                                                        : sat_dec(r_ccd_cnt);
            r_wtr_cnt <= (w_gnt_type == CMD_WR) ? t_wtr_m1 : sat_dec(r_wtr_cnt);
            r_rtw_cnt <= (w_gnt_type == CMD_RD) ? t_rtw_m1 : sat_dec(r_rtw_cnt);
            if (w_gnt_valid) r_rr_ptr <= w_gnt_ba + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            cmd_ba    <= '0;
            cmd_ra    <= '0;
            cmd_ca    <= '0;
            cmd_id    <= '0;
            cmd_len   <= '0;
        end else begin
            cmd_valid <= w_gnt_valid;
            cmd_type  <= w_gnt_type;
            if (w_gnt_valid) begin
                cmd_ba  <= w_gnt_ba;
                cmd_ra  <= ra_i[w_gnt_ba*RA_WIDTH +: RA_WIDTH];
                cmd_ca  <= ca_i[w_gnt_ba*CA_WIDTH +: CA_WIDTH];
                cmd_id  <= id_i[w_gnt_ba*ID_WIDTH +: ID_WIDTH];
                cmd_len <= len_i[w_gnt_ba*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dram_cmd_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_dram_cmd_arbiter
// Brief  : Directed self-checking bench for dram_cmd_arbiter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dram_cmd_arbiter;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
    logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NB*16-1:0] ra_i;
    logic [NB*10-1:0] ca_i;
    logic [NB*4-1:0]  id_i;
    logic [NB*4-1:0]  len_i;
    logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic          cmd_valid;
    logic [2:0]    cmd_type;
    logic [1:0]    cmd_ba;
    logic [15:0]   cmd_ra;
    logic [9:0]    cmd_ca;
    logic [3:0]    cmd_id;
    logic [3:0]    cmd_len;

    int n_checks = 0;
    int n_errors = 0;

    dram_cmd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .ra_i(ra_i), .ca_i(ca_i), .id_i(id_i), .len_i(len_i),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
        .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_reqs();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    endtask

    // Leaves the bench 1ns after the first edge following release (cycle 0).
    task automatic do_reset(input logic [3:0] rrd, input logic [3:0] ccd,
                            input logic [3:0] wtr, input logic [3:0] rtw);
        clr_reqs();
        t_rrd_m1 = rrd; t_ccd_m1 = ccd; t_wtr_m1 = wtr; t_rtw_m1 = rtw;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        for (int b = 0; b < NB; b++) begin
            ra_i[b*16 +: 16] = 16'h1000 + 16'(b * 16'h111);
            ca_i[b*10 +: 10] = 10'h100 + 10'(b);
            id_i[b*4 +: 4]   = 4'(b + 4);
            len_i[b*4 +: 4]  = 4'(b + 8);
        end
        clr_reqs();
        t_rrd_m1 = 0; t_ccd_m1 = 0; t_wtr_m1 = 0; t_rtw_m1 = 0;
        rst_n = 1'b0;
        #12;
        check("rst_valid", cmd_valid, 0);
        check("rst_type", cmd_type, 0);
        check("rst_ba_ra", {cmd_ba, cmd_ra}, 0);
        check("rst_gnts", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 0);

        // tRRD spacing with t_rrd_m1=3
        do_reset(4'd3, 4'd0, 4'd0, 4'd0);
        act_req = 4'b0001; #1;
        check("act0_gnt", act_gnt, 4'b0001);
        cyc(); act_req = 4'b0010; #1;
        check("act0_valid", cmd_valid, 1);
        check("act0_type", cmd_type, 1);
        check("act0_ba", cmd_ba, 0);
        check("rrd_c1", act_gnt, 0);
        cyc(); #1; check("rrd_c2", act_gnt, 0);
        cyc(); #1; check("rrd_c3", act_gnt, 0);
        cyc(); #1; check("rrd_c4", act_gnt, 4'b0010);
        cyc(); act_req = '0; #1;
        check("act1_ba", cmd_ba, 1);
        check("act1_ra", cmd_ra, 16'h1111);
        check("act1_ca", cmd_ca, 10'h101);
        check("act1_id_len", {cmd_id, cmd_len}, 8'h59);
        cyc(); #1;
        check("idle_valid", cmd_valid, 0);
        check("idle_ra_hold", cmd_ra, 16'h1111);

        // Round-robin RD with t_ccd_m1=1, including pointer wrap
        do_reset(4'd0, 4'd1, 4'd0, 4'd0);
        rd_req = 4'b1111; #1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin cyc(); #1; end
            check($sformatf("rr_rd_c%0d", c), rd_gnt,
                  (c % 2 == 0) ? (32'd1 << ((c / 2) % 4)) : 32'd0);
        end
        cyc(); rd_req = '0; #1;
        check("rr_last_ba", cmd_ba, 0);
        check("rr_last_type", cmd_type, 2);

        // tWTR: WR bank2 then RD bank3 waits until cycle 6
        do_reset(4'd0, 4'd1, 4'd5, 4'd0);
        wr_req = 4'b0100; #1;
        check("wtr_wr_gnt", wr_gnt, 4'b0100);
        cyc(); wr_req = '0; rd_req = 4'b1000; #1;
        check("wtr_wr_type", cmd_type, 3);
        check("wtr_wr_ba", cmd_ba, 2);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin cyc(); #1; end
            check($sformatf("wtr_c%0d", c), rd_gnt, (c == 6) ? 32'b1000 : 32'b0);
        end
        cyc(); rd_req = '0; #1;

        // tRTW: RD bank0 then WR bank1 waits until cycle 5
        do_reset(4'd0, 4'd0, 4'd0, 4'd4);
        rd_req = 4'b0001; #1;
        check("rtw_rd_gnt", rd_gnt, 4'b0001);
        cyc(); rd_req = '0; wr_req = 4'b0010; #1;
        check("rtw_rd_type", cmd_type, 2);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin cyc(); #1; end
            check($sformatf("rtw_c%0d", c), wr_gnt, (c == 5) ? 32'b0010 : 32'b0);
        end
        cyc(); wr_req = '0; #1;

        // Class priority REF > RD > ACT > PRE
        do_reset(4'd0, 4'd0, 4'd0, 4'd0);
        ref_req = 4'b0010; rd_req = 4'b0001; act_req = 4'b0100; pre_req = 4'b1000; #1;
        check("prio_ref", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 20'h00002);
        cyc(); ref_req = '0; #1;
        check("prio_rd", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 20'h01000);
        check("prio_ref_type", cmd_type, 5);
        cyc(); rd_req = '0; #1;
        check("prio_act", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 20'h40000);
        check("prio_rd_type", cmd_type, 2);
        cyc(); act_req = '0; #1;
        check("prio_pre", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 20'h00080);
        check("prio_act_type", cmd_type, 1);
        check("prio_onehot", $countones({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}) <= 1, 1);
        cyc(); pre_req = '0; #1;
        check("prio_pre_type", cmd_type, 4);
        check("prio_pre_ba", cmd_ba, 3);

        // Reset mid-count clears rrd_cnt
        do_reset(4'd3, 4'd0, 4'd0, 4'd0);
        act_req = 4'b0001; #1;
        check("mr_act0", act_gnt, 4'b0001);
        cyc(); act_req = 4'b0010; pre_req = 4'b1000; #1;
        check("mr_pre_gnt", pre_gnt, 4'b1000);
        check("mr_act_blk", act_gnt, 0);
        cyc(); pre_req = '0; #1;
        check("mr_valid_pre", cmd_valid, 1);
        check("mr_act_blk2", act_gnt, 0);
        rst_n = 1'b0; #1;
        check("mr_valid_rst", cmd_valid, 0);
        check("mr_type_rst", cmd_type, 0);
        cyc(); rst_n = 1'b1; #1;
        check("mr_act_after", act_gnt, 4'b0010);
        cyc(); act_req = '0; #1;
        check("mr_cmd", {cmd_valid, cmd_type, cmd_ba}, {1'b1, 3'd1, 2'd1});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
